// File: rtl/div_seq.sv
// div_seq: sequential restoring divider, one quotient bit per cycle.
// Defining DIV_SIGNED_EN makes it a two's-complement divider; otherwise it divides unsigned operands.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             dz
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_next;
    logic [WIDTH:0] a;
    logic [WIDTH-1:0] q, m, mag_n, mag_d, q_fix, r_fix;
    logic [CW-1:0] count;
    logic [WIDTH+1:0] shifted, diff;
    logic accept, zero;
    assign accept = (state == IDLE) && start;
    assign zero = (divisor == '0);
    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);
    // The top bit of diff is the sign of the trial subtraction.
    assign shifted = {a, q[WIDTH-1]};
    assign diff = shifted - {2'b00, m};
`ifdef DIV_SIGNED_EN
    logic neg_q, neg_r;
    assign mag_n = dividend[WIDTH-1] ? -dividend : dividend;
    assign mag_d = divisor[WIDTH-1] ? -divisor : divisor;
    assign q_fix = neg_q ? -q : q;
    assign r_fix = neg_r ? -a[WIDTH-1:0] : a[WIDTH-1:0];
    always_ff @(posedge clk) begin
        if (!rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign mag_n = dividend;
    assign mag_d = divisor;
    assign q_fix = q;
    assign r_fix = a[WIDTH-1:0];
`endif
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= state_next;
    end
    always_comb begin
        state_next = state;
        if (accept) state_next = zero ? DONE : CALC;
        else if (state == CALC) state_next = (count == CW'(WIDTH - 1)) ? FIX : CALC;
        else if (state == FIX) state_next = DONE;
        else if (state == DONE) state_next = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            a         <= '0;
            q         <= '0;
            m         <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
        end else if (accept) begin
            a     <= '0;
            q     <= mag_n;
            m     <= mag_d;
            count <= '0;
            dz    <= zero;
            if (zero) begin
                quotient  <= '1;
                remainder <= dividend;
            end
        end else if (state == CALC) begin
            a     <= diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
            q     <= {q[WIDTH-2:0], ~diff[WIDTH+1]};
            count <= count + CW'(1);
        end else if (state == FIX) begin
            quotient  <= q_fix;
            remainder <= r_fix;
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed vectors for div_seq with a queue scoreboard checked whenever done pulses.
module tb_div_seq;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          c;
    } exp_t;
    logic clk = 1'b0;
    logic rst, start, busy, done, dz;
    logic [31:0] dividend, divisor, quotient, remainder;
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int busy_cnt = 0;
    exp_t sb[$];
    exp_t me;

    div_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .dz(dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) busy_cnt = 0;
        else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
                end else begin
                    me = sb.pop_front();
                    check("quotient", quotient, me.q);
                    check("remainder", remainder, me.r);
                    check("dz", {31'b0, dz}, {31'b0, me.z});
                    check("done_cycle", 32'(cyc), 32'(me.c));
                    check("busy_cycles", 32'(busy_cnt), me.z ? 32'd0 : 32'd33);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_quotient"}, quotient, 32'h0);
        check({tag, "_remainder"}, remainder, 32'h0);
        check({tag, "_dz"}, {31'b0, dz}, 32'h0);
        check({tag, "_busy"}, {31'b0, busy}, 32'h0);
        check({tag, "_done"}, {31'b0, done}, 32'h0);
    endtask

    // Called at a negedge; the start is accepted at the following rising edge.
    task automatic issue(input logic [31:0] n, input logic [31:0] d,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez);
        dividend = n;
        divisor = d;
        start = 1'b1;
        sb.push_back('{eq, er, ez, cyc + 1 + (ez ? 0 : 33)});
        @(negedge clk);
        start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b1;
        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        drain();
        @(negedge clk) issue(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
        drain();
        @(negedge clk) issue(32'd3, 32'd5, 32'd0, 32'd3, 1'b0);
        drain();
        @(negedge clk) issue(32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1);
        drain();
        @(negedge clk) issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        drain();
        @(negedge clk) issue(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
        drain();
`ifdef DIV_SIGNED_EN
        @(negedge clk) issue(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        drain();
        @(negedge clk) issue(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
        drain();
        @(negedge clk) issue(32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
        drain();
`else
        @(negedge clk) issue(32'hFFFFFF9C, 32'd7, 32'h24924916, 32'd2, 1'b0);
        drain();
        @(negedge clk) issue(32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
        drain();
        @(negedge clk) issue(32'd7, 32'hFFFFFFFE, 32'd0, 32'd7, 1'b0);
        drain();
`endif
        @(negedge clk) issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        repeat (9) @(negedge clk);
        dividend = 32'd50;
        divisor = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (40) @(negedge clk);
        issue(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        if (sb.size() != 0) void'(sb.pop_back());
        check_idle("midreset");
        rst = 1'b1;
        issue(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
        drain();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
